// File: rtl/spi_slave_reg_bridge.sv
// SPI byte stream to register bus bridge: byte 0 of a frame is a command, later bytes carry write data or read dummies.
// Define SPI_BRIDGE_AUTOINC_EN to post-increment reg_addr per data byte; otherwise the address is fixed for the whole frame.
//
// state | meaning
// IDLE  | no frame open, waiting for a command byte
// WRITE | write frame, each byte is written to reg_addr
// READ  | read frame, each dummy byte requests the next read
// RCAP  | one cycle, capture reg_rdata into tx_data
module spi_slave_reg_bridge #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic                  ms_csb,
  input  logic [7:0]            spi_slave_rx_data,
  input  logic                  spi_slave_rx_new_it,
  output logic [7:0]            spi_slave_tx_data,
  output logic                  spi_slave_tx_empty_it,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [7:0]            reg_rdata,
  output logic                  bridge_busy
);

`ifdef SPI_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RCAP} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  csb_sync;
  logic                    csb_s;
  logic [PRIME_W-1:0]      prime_cnt;
  logic                    primed;
  logic                    armed;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [7:0]              wdata_nxt;
  logic [7:0]              tx_data_nxt;
  logic                    wr_nxt;
  logic                    rd_nxt;
  logic                    tx_empty_nxt;

  assign csb_s       = csb_sync[SYNC_STAGES-1];
  assign primed      = (prime_cnt == '0);
  assign bridge_busy = (state != IDLE);

  // csb_s only reflects the real pin once the reset value has flushed out of
  // the synchroniser; a frame may only be decoded after a genuine csb high.
  always_ff @(posedge clk) begin
    if (rst) begin
      csb_sync  <= '1;
      prime_cnt <= PRIME_W'(SYNC_STAGES);
      armed     <= 1'b0;
    end else begin
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], ms_csb};
      if (!primed) begin
        prime_cnt <= prime_cnt - 1'b1;
      end
      if (csb_s && primed) begin
        armed <= 1'b1;
      end else if (!csb_s && !cfg_enable) begin
        armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      reg_addr              <= '0;
      reg_wdata             <= '0;
      reg_wr                <= 1'b0;
      reg_rd                <= 1'b0;
      spi_slave_tx_data     <= '0;
      spi_slave_tx_empty_it <= 1'b0;
    end else begin
      state                 <= state_nxt;
      reg_addr              <= addr_nxt;
      reg_wdata             <= wdata_nxt;
      reg_wr                <= wr_nxt;
      reg_rd                <= rd_nxt;
      spi_slave_tx_data     <= tx_data_nxt;
      spi_slave_tx_empty_it <= tx_empty_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = reg_addr;
    wdata_nxt    = reg_wdata;
    tx_data_nxt  = spi_slave_tx_data;
    wr_nxt       = 1'b0;
    rd_nxt       = 1'b0;
    tx_empty_nxt = 1'b0;

    // Write address advances the cycle after the strobe it was used for.
    if (AUTOINC && reg_wr) begin
      addr_nxt = reg_addr + 1'b1;
    end
    if (state == IDLE) begin
      tx_data_nxt = '0;
    end

    if (csb_s) begin
      state_nxt = IDLE;
    end else if ((state != IDLE) && !cfg_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (spi_slave_rx_new_it && cfg_enable && armed) begin
            addr_nxt = spi_slave_rx_data[ADDR_WIDTH-1:0];
            if (spi_slave_rx_data[7]) begin
              state_nxt = WRITE;
            end else begin
              rd_nxt    = 1'b1;
              state_nxt = RCAP;
            end
          end
        end
        WRITE: begin
          if (spi_slave_rx_new_it) begin
            wdata_nxt = spi_slave_rx_data;
            wr_nxt    = 1'b1;
          end
        end
        RCAP: begin
          tx_data_nxt  = reg_rdata;
          tx_empty_nxt = 1'b1;
          state_nxt    = READ;
        end
        READ: begin
          if (spi_slave_rx_new_it) begin
            if (AUTOINC) begin
              addr_nxt = reg_addr + 1'b1;
            end
            rd_nxt    = 1'b1;
            state_nxt = RCAP;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// Directed bench for spi_slave_reg_bridge; expectations follow SPI_BRIDGE_AUTOINC_EN when it is defined.
module tb_spi_slave_reg_bridge;

`ifdef SPI_BRIDGE_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_enable;
  logic       ms_csb;
  logic [7:0] rx_data;
  logic       rx_new;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;

  logic [7:0] rmem [0:127];
  int         n_err = 0;
  int         n_chk = 0;
  int         wr_n = 0;
  int         rd_n = 0;
  int         tx_n = 0;
  logic [6:0] wr_addr [0:15];
  logic [7:0] wr_data [0:15];

  always #5 clk = ~clk;

  assign reg_rdata = rmem[reg_addr];

  spi_slave_reg_bridge #(.ADDR_WIDTH(7), .SYNC_STAGES(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cfg_enable            (cfg_enable),
    .ms_csb                (ms_csb),
    .spi_slave_rx_data     (rx_data),
    .spi_slave_rx_new_it   (rx_new),
    .spi_slave_tx_data     (tx_data),
    .spi_slave_tx_empty_it (tx_empty),
    .reg_addr              (reg_addr),
    .reg_wdata             (reg_wdata),
    .reg_wr                (reg_wr),
    .reg_rd                (reg_rd),
    .reg_rdata             (reg_rdata),
    .bridge_busy           (busy)
  );

  always @(negedge clk) begin
    if (reg_wr && wr_n < 16) begin
      wr_addr[wr_n] = reg_addr;
      wr_data[wr_n] = reg_wdata;
      wr_n++;
    end
    if (reg_rd) rd_n++;
    if (tx_empty) tx_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [7:0] b);
    rx_data = b;
    rx_new  = 1'b1;
    tick();
    rx_new  = 1'b0;
  endtask

  task automatic open_frame();
    ms_csb = 1'b0;
    gap(4);
  endtask

  task automatic close_frame();
    ms_csb = 1'b1;
    gap(5);
  endtask

  task automatic clear_logs();
    wr_n = 0;
    rd_n = 0;
    tx_n = 0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rmem[i] = 8'h00;
    rmem[7'h10] = 8'h11;
    rmem[7'h11] = 8'h22;
    rmem[7'h12] = 8'h33;

    rst = 1'b1; cfg_enable = 1'b1; ms_csb = 1'b1; rx_data = 8'h00; rx_new = 1'b0;
    gap(3);
    check("rst_busy", busy, 0);
    check("rst_wr", reg_wr, 0);
    check("rst_rd", reg_rd, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_tx", tx_data, 0);
    check("rst_txe", tx_empty, 0);
    rst = 1'b0;
    gap(4);

    // single write 0x85, 0x3C
    clear_logs();
    open_frame();
    pulse(8'h85);
    check("t1_busy", busy, 1);
    check("t1_cmd_addr", reg_addr, 7'h05);
    check("t1_cmd_nowr", reg_wr, 0);
    gap(7);
    pulse(8'h3C);
    check("t1_wr", reg_wr, 1);
    check("t1_addr", reg_addr, 7'h05);
    check("t1_wdata", reg_wdata, 8'h3C);
    tick();
    check("t1_wr_done", reg_wr, 0);
    check("t1_addr_post", reg_addr, AI ? 7'h06 : 7'h05);
    gap(6);
    close_frame();
    check("t1_idle", busy, 0);
    check("t1_wr_count", wr_n, 1);

    // read 0x10 + two dummies
    clear_logs();
    open_frame();
    pulse(8'h10);
    check("t2_rd0", reg_rd, 1);
    check("t2_addr0", reg_addr, 7'h10);
    tick();
    check("t2_txe0", tx_empty, 1);
    check("t2_tx0", tx_data, 8'h11);
    check("t2_rd0_done", reg_rd, 0);
    gap(6);
    pulse(8'h00);
    check("t2_rd1", reg_rd, 1);
    check("t2_addr1", reg_addr, AI ? 7'h11 : 7'h10);
    tick();
    check("t2_txe1", tx_empty, 1);
    check("t2_tx1", tx_data, AI ? 8'h22 : 8'h11);
    gap(6);
    pulse(8'h00);
    check("t2_addr2", reg_addr, AI ? 7'h12 : 7'h10);
    tick();
    check("t2_tx2", tx_data, AI ? 8'h33 : 8'h11);
    gap(6);
    close_frame();
    check("t2_rd_count", rd_n, 3);
    check("t2_tx_count", tx_n, 3);
    check("t2_wr_count", wr_n, 0);
    check("t2_tx_cleared", tx_data, 0);

    // write at max address then three data bytes
    clear_logs();
    open_frame();
    pulse(8'hFF);
    gap(7);
    for (int i = 0; i < 3; i++) begin
      pulse(8'hA1 + 8'(i));
      gap(7);
    end
    close_frame();
    check("t3_wr_count", wr_n, 3);
    check("t3_addr0", wr_addr[0], 7'h7F);
    check("t3_addr1", wr_addr[1], AI ? 7'h00 : 7'h7F);
    check("t3_addr2", wr_addr[2], AI ? 7'h01 : 7'h7F);
    check("t3_data0", wr_data[0], 8'hA1);
    check("t3_data2", wr_data[2], 8'hA3);

    // csb_s rises in the same cycle as a data byte
    clear_logs();
    open_frame();
    pulse(8'h85);
    gap(7);
    ms_csb = 1'b1;
    tick();
    tick();
    check("t4_busy_before", busy, 1);
    pulse(8'h77);
    check("t4_nowr", reg_wr, 0);
    check("t4_idle", busy, 0);
    gap(4);
    check("t4_wr_count", wr_n, 0);

    // bridge disabled
    cfg_enable = 1'b0;
    clear_logs();
    open_frame();
    pulse(8'h85);
    check("t5_busy", busy, 0);
    gap(7);
    pulse(8'hAA);
    check("t5_nowr", reg_wr, 0);
    gap(7);
    close_frame();
    check("t5_wr_count", wr_n, 0);
    check("t5_rd_count", rd_n, 0);
    cfg_enable = 1'b1;

    // reset mid-burst, remaining bytes of the frame ignored
    clear_logs();
    open_frame();
    pulse(8'h90);
    gap(7);
    pulse(8'h01);
    check("t6_wr_pre", reg_wr, 1);
    check("t6_addr_pre", reg_addr, 7'h10);
    gap(3);
    rst = 1'b1;
    tick();
    check("t6_rst_busy", busy, 0);
    check("t6_rst_addr", reg_addr, 0);
    check("t6_rst_wdata", reg_wdata, 0);
    tick();
    rst = 1'b0;
    gap(4);
    clear_logs();
    pulse(8'h85);
    check("t6_ignored_busy", busy, 0);
    gap(7);
    pulse(8'h55);
    check("t6_ignored_wr", reg_wr, 0);
    gap(7);
    check("t6_ignored_count", wr_n, 0);
    close_frame();
    open_frame();
    pulse(8'h85);
    check("t6_new_busy", busy, 1);
    gap(7);
    pulse(8'h66);
    check("t6_new_wr", reg_wr, 1);
    check("t6_new_addr", reg_addr, 7'h05);
    check("t6_new_wdata", reg_wdata, 8'h66);
    gap(7);
    close_frame();
    check("t6_new_count", wr_n, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
